operand_b_fwd_ctrl: RTL

OPERAND_B_FWD_CTRL -- requirements
Module: mod_operand_b_fwd_ctrl

---
 rtl/operand_b_fwd_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/operand_b_fwd_ctrl.sv
// rtl/operand_b_fwd_ctrl.sv - operand-B forwarding select and load-use stall control (optional FWD_STATS_EN counters)
module operand_b_fwd_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic        id_alu_src,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        hold,
  input  logic        flush,
  output logic        issue,
  output logic        stall,
  output logic [1:0]  ex_b_sel,
  output logic        ex_valid
`ifdef FWD_STATS_EN
  ,
  output logic [15:0] fwd_cnt,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, STALL_LU = 1'b1} state_t;

  state_t     state;
  state_t     state_nxt;

  // EX slot
  logic       ex_v;
  logic [4:0] ex_rd;
  logic       ex_rw;
  logic       ex_mr;
  logic [1:0] ex_sel;

  // MEM slot
  logic       mem_v;
  logic [4:0] mem_rd;
  logic       mem_rw;

  logic       hazard;
  logic       advance;
  logic [1:0] id_sel;

  // A load in EX whose destination feeds rs2 cannot be forwarded in time.
  assign hazard = id_valid && id_uses_rs2 && !id_alu_src
               && ex_v && ex_mr && ex_rw
               && (ex_rd == id_rs2) && (id_rs2 != 5'd0);

  // Slots move on every edge unless frozen; flush still pushes EX into MEM.
  assign advance = !hold || flush;

  // Operand-B select for the decode instruction, EX result preferred over MEM.
  always_comb begin
    id_sel = 2'b00;
    if (id_alu_src) begin
      id_sel = 2'b01;
    end else if (id_uses_rs2 && (id_rs2 != 5'd0)) begin
      if (ex_v && ex_rw && !ex_mr && (ex_rd == id_rs2)) begin
        id_sel = 2'b10;
      end else if (mem_v && mem_rw && (mem_rd == id_rs2)) begin
        id_sel = 2'b11;
      end
    end
  end

  // FSM state register; reset and flush both return to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a stall lasts one advancing edge, hold freezes it.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RUN;
    end else if (!hold) begin
      case (state)
        RUN:      if (stall) state_nxt = STALL_LU;
        STALL_LU: state_nxt = RUN;
        default:  state_nxt = RUN;
      endcase
    end
  end

  // FSM outputs: stall/issue are suppressed by reset, hold and flush.
  always_comb begin
    stall = 1'b0;
    issue = 1'b0;
    if (!rst && !hold && !flush) begin
      stall = hazard && (state == RUN);
      issue = id_valid && !hazard;
    end
  end

  // Pipeline slots: EX shifts to MEM, EX takes the issued instruction or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v   <= 1'b0;
      ex_rd  <= 5'd0;
      ex_rw  <= 1'b0;
      ex_mr  <= 1'b0;
      ex_sel <= 2'b00;
      mem_v  <= 1'b0;
      mem_rd <= 5'd0;
      mem_rw <= 1'b0;
    end else if (advance) begin
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      mem_rw <= ex_rw;
      if (issue) begin
        ex_v   <= 1'b1;
        ex_rd  <= id_rd;
        ex_rw  <= id_reg_write;
        ex_mr  <= id_mem_read;
        ex_sel <= id_sel;
      end else begin
        ex_v   <= 1'b0;
        ex_rd  <= 5'd0;
        ex_rw  <= 1'b0;
        ex_mr  <= 1'b0;
        ex_sel <= 2'b00;
      end
    end
  end

  assign ex_valid = ex_v;
  assign ex_b_sel = ex_sel;

`ifdef FWD_STATS_EN
  // Saturating counters of forwarded issues and load-use stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt   <= 16'd0;
      stall_cnt <= 16'd0;
    end else if (!hold) begin
      if (issue && id_sel[1] && (fwd_cnt != 16'hFFFF)) begin
        fwd_cnt <= fwd_cnt + 16'd1;
      end
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
